// File: rtl/alu_pkg.sv
// Shared definitions for the ALU, its round-robin arbiter and the arbiter top.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    // Codes 3, 4 and 5 are not part of the supported alucount set.
    function automatic logic op_legal(input logic [2:0] op);
        return !(op inside {3'd3, 3'd4, 3'd5});
    endfunction

endpackage

// File: rtl/alu.sv
// Existing 32-bit ALU: AND/OR/ADD/SUB/signed SLT selected by alucount.
// Codes 4/5 use the inverted b operand; code 3 yields zero.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alucount,
    output logic [31:0] result,
    output logic        zero
);

    // Select the operation result and derive the zero flag.
    always_comb begin
        result = '0;
        case (alucount)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            3'd4:    result = a & ~b;
            3'd5:    result = a | ~b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: with both requesters valid, the one that was
// not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_any,
    output logic       grant_id
);

    // Pick the single valid requester, or alternate on contention.
    always_comb begin
        grant_any = |valid;
        grant_id  = 1'b0;
        if (valid == 2'b11) begin
            grant_id = ~last_grant;
        end else if (valid[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: accept in IDLE, compute in EXEC,
// hold the response in RESP until the owner takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHECK_OP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,
    output logic             busy
);

    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             grant_any, grant_id;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant_any  (grant_any),
        .grant_id   (grant_id)
    );

    // ALU sees only the captured operands, never the live request inputs.
    alu u_alu (
        .a        (a_q),
        .b        (b_q),
        .alucount (op_q),
        .result   (alu_result),
        .zero     (alu_zero)
    );

    // State, grant history, captured operands and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

    // Next-state, capture and request-ready logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        zero_d       = zero_q;
        err_d        = err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    owner_d    = grant_id;
                    a_d        = grant_id ? req1_a  : req0_a;
                    b_d        = grant_id ? req1_b  : req0_b;
                    op_d       = grant_id ? req1_op : req0_op;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                err_d    = (CHECK_OP != 0) && !op_legal(op_q);
                result_d = err_d ? '0 : alu_result;
                zero_d   = err_d ? 1'b0 : alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp0_valid  = (state_q == RESP) && !owner_q;
    assign rsp1_valid  = (state_q == RESP) &&  owner_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign rsp0_err    = err_q;
    assign rsp1_err    = err_q;
    assign busy        = (state_q != IDLE);

endmodule
